// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared constants and state encoding for the program loader
// The CHK state exists only when PROG_LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;
  localparam int DEFAULT_WORD_BYTES = 3;
  localparam int WORD_W             = 8 * DEFAULT_WORD_BYTES;
  localparam int DEFAULT_ADDR_W     = 8;
  localparam int DEFAULT_DEPTH      = 255;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_e;
endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte stream in, instruction-memory write port out
// master = loader side, slave = byte source plus memory.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int WR_DATA_W = WORD_W
);
  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [WR_DATA_W-1:0] wr_data;

  modport master (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/prog_loader_word_asm.sv
// rtl/prog_loader_word_asm.sv - big-endian byte-to-word shift register
// word_full_o flags the strobe that carries the last byte of a word.
module prog_loader_word_asm #(
  parameter int WORD_BYTES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_i,
  input  logic                    strobe_i,
  input  logic [7:0]              byte_i,
  output logic [8*WORD_BYTES-1:0] word_o,
  output logic                    word_full_o
);
  localparam int W     = 8 * WORD_BYTES;
  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  logic [IDX_W-1:0] idx_q;
  logic [W-1:0]     word_q;

  assign word_full_o = strobe_i && (idx_q == IDX_W'(WORD_BYTES - 1));
  assign word_o      = word_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (strobe_i) begin
      // First byte ends up in the top lane after WORD_BYTES shifts.
      word_q <= (word_q << 8) | W'(byte_i);
      idx_q  <= word_full_o ? '0 : idx_q + IDX_W'(1);
    end
  end
endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - loads a length-prefixed byte stream into instruction memory
// Define PROG_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int WORD_BYTES = DEFAULT_WORD_BYTES,
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  prog_loader_if.master bus,
  output logic          busy_o,
  output logic          done_o,
  output logic          error_o,
  output logic          cpu_hold_o
);
  localparam int WR_W  = 8 * WORD_BYTES;
  localparam int CNT_W = (ADDR_W > 8) ? ADDR_W + 1 : 9;

  state_e            state_q;
  logic              in_ready_q;
  logic              wr_en_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        n_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q;
`endif

  logic [WR_W-1:0] word;
  logic            word_full;
  logic            xfer;
  logic            start_ok;
  logic            len_bad;
  logic            last_word;

  assign xfer      = bus.in_valid && in_ready_q;
  assign start_ok  = start_i && (state_q == IDLE || state_q == DONE || state_q == ERR);
  assign len_bad   = (bus.in_data == 8'd0) || (32'(bus.in_data) > 32'(DEPTH));
  assign last_word = (CNT_W'(addr_q) + CNT_W'(1)) == CNT_W'(n_q);

  prog_loader_word_asm #(.WORD_BYTES(WORD_BYTES)) u_word_asm (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (start_ok),
    .strobe_i    (xfer && (state_q == DATA)),
    .byte_i      (bus.in_data),
    .word_o      (word),
    .word_full_o (word_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      addr_q     <= '0;
      n_q        <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE, ERR: begin
          if (start_i) begin
            state_q    <= LEN;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            addr_q     <= '0;
            n_q        <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
          end
        end
        LEN: begin
          if (xfer) begin
            n_q <= bus.in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q <= sum_q + bus.in_data;
`endif
            if (len_bad) begin
              state_q    <= ERR;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              error_q    <= 1'b1;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q <= sum_q + bus.in_data;
`endif
            if (word_full) begin
              state_q    <= WRITE;
              in_ready_q <= 1'b0;
              wr_en_q    <= 1'b1;
            end
          end
        end
        WRITE: begin
          // The address stops at N-1 so it never points past the loaded image.
          if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_q    <= CHK;
            in_ready_q <= 1'b1;
`else
            state_q    <= DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
`endif
          end else begin
            state_q    <= DATA;
            in_ready_q <= 1'b1;
            addr_q     <= addr_q + ADDR_W'(1);
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if ((sum_q + bus.in_data) == 8'd0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ERR;
              error_q <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = addr_q;
  assign bus.wr_data  = word;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign cpu_hold_o   = (state_q != IDLE) && (state_q != DONE) && (state_q != ERR);
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction store.
- Receives a byte stream from a byte source (UART RX or debug port) over a valid/ready handshake.
- Assembles each group of 3 bytes into a 24-bit instruction word and writes it into instruction memory at consecutive addresses starting from 0.
- Holds the CPU core in reset while loading, so the fetch side starts at address 0 once the load completes.

Parameters:
- WORD_BYTES, 3, bytes per instruction word.
- ADDR_W, 8, instruction memory address width.
- DEPTH, 255, number of writable words; valid addresses are 0..DEPTH-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only when not busy.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle; transfer occurs when in_valid & in_ready.
- wr_en  out  1  memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  8*WORD_BYTES  write word.
- busy  out  1  load in progress.
- done  out  1  last load completed successfully; sticky.
- error  out  1  last load aborted; sticky.
- cpu_hold  out  1  CPU reset request; equals busy.

Behaviour:
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, cpu_hold=0, state=IDLE. Internal counters are also cleared.
- Reset mid-load: abort at the next edge; no further writes are issued.
- Packet format: byte 0 = word count N, then N*WORD_BYTES payload bytes.
- Byte order within a word is big-endian: the first byte lands in bits [23:16] and the last in [7:0].
- States: IDLE, LEN, DATA, WRITE, CHK (optional), DONE, ERR.
- IDLE
  - in_ready=0.
  - start -> LEN. On entry, clear done/error, byte index, word counter and address; set busy=1.
- LEN
  - in_ready=1.
  - On transfer, latch N.
  - N==0 or N>DEPTH -> ERR. Otherwise -> DATA.
- DATA
  - in_ready=1.
  - Each transfer shifts the byte into the word register and increments the byte index (0..WORD_BYTES-1).
  - On the WORD_BYTES-th byte -> WRITE.
- WRITE (exactly one cycle)
  - in_ready=0.
  - wr_en=1, wr_addr = word counter, wr_data = assembled word.
  - Next cycle: wr_addr increments; byte index resets to 0.
  - If words written == N -> DONE (or CHK when enabled). Otherwise -> DATA.
  - Throughput: at most 1 word per WORD_BYTES+1 cycles.
- DONE
  - busy=0, done=1.
  - Waits for start, which behaves as in IDLE (restart allowed).
- ERR
  - busy=0, error=1.
  - Waits for start, which behaves as in IDLE.
  - Words already written are not rolled back.
- start while busy: ignored.
- in_valid while in_ready=0: no transfer; the byte is not consumed.
- wr_en is never asserted outside WRITE.
- wr_addr never exceeds N-1; no wrap-around is possible because N<=DEPTH.
- cpu_hold tracks busy combinationally from the state register.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Enabled
  - A running 8-bit sum (mod 256) covers the length byte and all payload bytes.
  - After the last WRITE, enter CHK with in_ready=1 and accept one checksum byte.
  - If (sum + checksum byte) mod 256 == 0 -> DONE; otherwise -> ERR.
- Disabled
  - No CHK state and no sum register.
  - The last WRITE goes directly to DONE.

Decomposition:
- Shared package: state encoding enum, WORD_W = 8*WORD_BYTES, and the default ADDR_W/DEPTH constants, reused by the instruction memory.
- One sub-module: prog_loader_word_asm.
  - Shift register plus byte index.
  - Inputs: byte/strobe/clear.
  - Outputs: word and word_full.
- Everything else stays flat in prog_loader.

Test Plan:
- Basic load:
  - Stimulus: start; bytes 02,11,22,33,44,55,66 with in_valid held high.
  - Response: wr_en exactly twice, (addr 0, 0x112233) then (addr 1, 0x445566); done=1; busy/cpu_hold drop in the cycle after the second write; in_ready=0 during each WRITE cycle.
- Zero/overflow length:
  - Stimulus: start; length 00 -> error=1, no wr_en. Then start; length FF with DEPTH=254 -> error=1.
- Backpressure/gaps:
  - Stimulus: N=1 with in_valid toggling 1,0,0,1,0,1.
  - Response: a single write of the correct word; bytes presented while in_ready=0 are not consumed.
- Reset mid-load:
  - Stimulus: start, length 03, 4 payload bytes, then rst for 1 cycle.
  - Response: only addr 0 was written; all outputs at reset values; a subsequent start reloads from addr 0.
- start while busy:
  - Stimulus: pulse start during DATA.
  - Response: no state change; the load completes normally with done=1.
- Checksum (PROG_LOADER_CHECKSUM_EN):
  - Stimulus: N=1, bytes 01,10,20,30, checksum 9F.
  - Response: 01+10+20+30+9F = 0x100 ≡ 0x00 -> done=1. The same stream with checksum 00 -> error=1, with the write to addr 0 still performed.
